// File: rtl/rf_writeback_unit.sv
// Write-back stage of the 3-stage RISC-V pipeline: retires instructions from execute,
// waits for and formats load data, drives the register file write port and forwards it.
module rf_writeback_unit #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_regwrite,
    input  logic [4:0]      ex_rd,
    input  logic [1:0]      ex_wbsel,
    input  logic [XLEN-1:0] ex_alu,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [2:0]      ex_funct3,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic [4:0]      fwd_raddr1,
    input  logic [4:0]      fwd_raddr2,
    output logic            rfwrite,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    output logic            wb_stall,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
    output logic            load_timeout
);

    localparam int CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wbState_t;

    wbState_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            rfwrite_q, rfwrite_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            timeout_q, timeout_d;
    logic [4:0]      ldRd_q, ldRd_d;
    logic            ldRegwrite_q, ldRegwrite_d;
    logic [2:0]      ldFunct3_q, ldFunct3_d;
    logic [1:0]      ldOffset_q, ldOffset_d;

    logic [XLEN-1:0] nonLoadData;
    logic [XLEN-1:0] loadData;

    // Byte lanes are picked from the aligned word by the low address bits of the load.
    function automatic logic [XLEN-1:0] formatLoad(
        input logic [2:0]      funct3,
        input logic [1:0]      offset,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  lane8;
        logic [15:0] lane16;
        lane8  = word[{offset, 3'b000} +: 8];
        lane16 = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  formatLoad = {{(XLEN-8){lane8[7]}}, lane8};
            3'b001:  formatLoad = {{(XLEN-16){lane16[15]}}, lane16};
            3'b100:  formatLoad = {{(XLEN-8){1'b0}}, lane8};
            3'b101:  formatLoad = {{(XLEN-16){1'b0}}, lane16};
            default: formatLoad = word;
        endcase
    endfunction

    always_comb begin
        case (ex_wbsel)
            WB_ALU:  nonLoadData = ex_alu;
            WB_PC4:  nonLoadData = ex_pc + XLEN'(4);
            default: nonLoadData = ex_imm;
        endcase
        loadData = formatLoad(ldFunct3_q, ldOffset_q, dmem_rdata);
    end

    // Next-state logic. Only IDLE accepts, which is exactly ex_valid with wb_stall low;
    // rfwrite defaults low so every write lasts a single cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rfwrite_d    = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        timeout_d    = timeout_q;
        ldRd_d       = ldRd_q;
        ldRegwrite_d = ldRegwrite_q;
        ldFunct3_d   = ldFunct3_q;
        ldOffset_d   = ldOffset_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_wbsel == WB_LOAD) begin
                        ldRd_d       = ex_rd;
                        ldRegwrite_d = ex_regwrite;
                        ldFunct3_d   = ex_funct3;
                        ldOffset_d   = ex_alu[1:0];
                        cnt_d        = '0;
                        state_d      = LOAD_WAIT;
                    end else begin
                        rfwrite_d = ex_regwrite && (ex_rd != 5'd0);
                        waddr_d   = ex_rd;
                        wdata_d   = nonLoadData;
                    end
                end
            end
            LOAD_WAIT: begin
                if (dmem_rvalid) begin
                    rfwrite_d = ldRegwrite_q && (ldRd_q != 5'd0);
                    waddr_d   = ldRd_q;
                    wdata_d   = loadData;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rfwrite_q    <= 1'b0;
            waddr_q      <= 5'd0;
            wdata_q      <= '0;
            timeout_q    <= 1'b0;
            ldRd_q       <= 5'd0;
            ldRegwrite_q <= 1'b0;
            ldFunct3_q   <= 3'd0;
            ldOffset_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rfwrite_q    <= rfwrite_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            timeout_q    <= timeout_d;
            ldRd_q       <= ldRd_d;
            ldRegwrite_q <= ldRegwrite_d;
            ldFunct3_q   <= ldFunct3_d;
            ldOffset_q   <= ldOffset_d;
        end
    end

    // Forwarding looks only at registered outputs, so it cannot form a loop with decode.
    assign fwd_hit1  = rfwrite_q && (waddr_q != 5'd0) && (waddr_q == fwd_raddr1);
    assign fwd_hit2  = rfwrite_q && (waddr_q != 5'd0) && (waddr_q == fwd_raddr2);
    assign fwd_data1 = fwd_hit1 ? wdata_q : '0;
    assign fwd_data2 = fwd_hit2 ? wdata_q : '0;

    assign rfwrite      = rfwrite_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign wb_stall     = (state_q == LOAD_WAIT);
    assign load_timeout = timeout_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Scoreboard bench for rf_writeback_unit: directed instructions push expected writes,
// a negedge monitor pops and compares every register file write.
module tb_rf_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_regwrite;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wbsel;
    logic [31:0] ex_alu;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [2:0]  ex_funct3;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  fwd_raddr1;
    logic [4:0]  fwd_raddr2;
    logic        rfwrite;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wb_stall;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic        load_timeout;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wbExp_t;

    wbExp_t expQ[$];
    wbExp_t monExp;
    int     checks   = 0;
    int     failures = 0;

    rf_writeback_unit #(.XLEN(32), .LOAD_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_regwrite  (ex_regwrite),
        .ex_rd        (ex_rd),
        .ex_wbsel     (ex_wbsel),
        .ex_alu       (ex_alu),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_funct3    (ex_funct3),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .fwd_raddr1   (fwd_raddr1),
        .fwd_raddr2   (fwd_raddr2),
        .rfwrite      (rfwrite),
        .waddr        (waddr),
        .wdata        (wdata),
        .wb_stall     (wb_stall),
        .fwd_hit1     (fwd_hit1),
        .fwd_hit2     (fwd_hit2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2),
        .load_timeout (load_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Presents one instruction and holds it until the DUT accepts it (stall low before the edge).
    task automatic applyStimulus(input logic regwrite, input logic [4:0] rd, input logic [1:0] wbsel,
                                 input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [2:0] funct3);
        logic accepted;
        logic stalled;
        @(posedge clk);
        #1;
        ex_valid    = 1'b1;
        ex_regwrite = regwrite;
        ex_rd       = rd;
        ex_wbsel    = wbsel;
        ex_alu      = alu;
        ex_pc       = pc;
        ex_imm      = imm;
        ex_funct3   = funct3;
        accepted    = 1'b0;
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge clk);
            stalled = wb_stall;
            @(posedge clk);
            if (!stalled) accepted = 1'b1;
        end
        #1;
        ex_valid = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_wait: got no accept expected accept within 64 cycles");
        end
    endtask

    task automatic doNonLoad(input logic regwrite, input logic [4:0] rd, input logic [1:0] wbsel,
                             input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] expData);
        if (regwrite && rd != 5'd0) expQ.push_back('{addr: rd, data: expData});
        applyStimulus(regwrite, rd, wbsel, alu, pc, imm, 3'b000);
    endtask

    // Load with 'delay' empty LOAD_WAIT cycles before the rvalid cycle.
    task automatic doLoad(input logic [4:0] rd, input logic [2:0] funct3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int delay, input logic [31:0] expData);
        applyStimulus(1'b1, rd, 2'b01, addr, 32'h0, 32'h0, funct3);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput("load_wait_stall", wb_stall, 1);
            @(posedge clk);
            #1;
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        if (rd != 5'd0) expQ.push_back('{addr: rd, data: expData});
        @(negedge clk);
        checkOutput("rvalid_cycle_stall", wb_stall, 1);
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("post_load_stall", wb_stall, 0);
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (rfwrite === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write: got waddr=%0d wdata=0x%08h expected no write", waddr, wdata);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("wb_waddr", {27'd0, waddr}, {27'd0, monExp.addr});
                    checkOutput("wb_wdata", wdata, monExp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        ex_regwrite = 1'b0;
        ex_rd       = 5'd0;
        ex_wbsel    = 2'b00;
        ex_alu      = 32'h0;
        ex_pc       = 32'h0;
        ex_imm      = 32'h0;
        ex_funct3   = 3'b000;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        fwd_raddr1  = 5'd0;
        fwd_raddr2  = 5'd0;

        #12;
        checkOutput("reset_rfwrite", rfwrite, 0);
        checkOutput("reset_waddr", {27'd0, waddr}, 0);
        checkOutput("reset_wdata", wdata, 0);
        checkOutput("reset_stall", wb_stall, 0);
        checkOutput("reset_timeout", load_timeout, 0);
        #5 rst_n = 1'b1;

        $display("[TB] ALU write and asynchronous reset");
        doNonLoad(1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234);
        checkOutput("alu_rfwrite_now", rfwrite, 1);
        @(posedge clk);
        #1;
        checkOutput("alu_rfwrite_next", rfwrite, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_waddr", {27'd0, waddr}, 0);
        checkOutput("async_reset_wdata", wdata, 0);
        checkOutput("async_reset_rfwrite", rfwrite, 0);
        #3 rst_n = 1'b1;

        $display("[TB] PC+4 wrap, immediate, x0 and no-regwrite");
        doNonLoad(1'b1, 5'd1, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000);
        doNonLoad(1'b1, 5'd2, 2'b11, 32'h0, 32'h0, 32'hABCD_E000, 32'hABCD_E000);
        fwd_raddr1 = 5'd0;
        doNonLoad(1'b1, 5'd0, 2'b00, 32'h5555_5555, 32'h0, 32'h0, 32'h0);
        checkOutput("x0_rfwrite", rfwrite, 0);
        checkOutput("x0_fwd_hit", fwd_hit1, 0);
        doNonLoad(1'b0, 5'd4, 2'b00, 32'h4444_4444, 32'h0, 32'h0, 32'h0);
        checkOutput("noregwrite_rfwrite", rfwrite, 0);

        $display("[TB] Load formatting");
        doLoad(5'd3,  3'b000, 32'h0000_1002, 32'h0080_0000, 2, 32'hFFFF_FF80);
        doLoad(5'd4,  3'b100, 32'h0000_1002, 32'h0080_0000, 2, 32'h0000_0080);
        doLoad(5'd5,  3'b001, 32'h0000_2002, 32'h8001_0000, 0, 32'hFFFF_8001);
        doLoad(5'd6,  3'b101, 32'h0000_2000, 32'h1234_ABCD, 1, 32'h0000_ABCD);
        doLoad(5'd7,  3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        doLoad(5'd8,  3'b011, 32'h0000_3000, 32'h0123_4567, 0, 32'h0123_4567);
        doLoad(5'd9,  3'b000, 32'h0000_4003, 32'h7F00_0000, 0, 32'h0000_007F);
        doLoad(5'd10, 3'b100, 32'h0000_4001, 32'h0000_C300, 3, 32'h0000_00C3);
        doLoad(5'd0,  3'b010, 32'h0000_5000, 32'hFFFF_FFFF, 1, 32'h0);

        $display("[TB] Back-to-back load then ALU");
        applyStimulus(1'b1, 5'd7, 2'b01, 32'h0000_6000, 32'h0, 32'h0, 3'b010);
        ex_valid    = 1'b1;
        ex_regwrite = 1'b1;
        ex_rd       = 5'd8;
        ex_wbsel    = 2'b00;
        ex_alu      = 32'h0000_0088;
        @(negedge clk);
        checkOutput("b2b_hold_stall", wb_stall, 1);
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_0077;
        expQ.push_back('{addr: 5'd7, data: 32'h0000_0077});
        @(negedge clk);
        checkOutput("b2b_rvalid_stall", wb_stall, 1);
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        expQ.push_back('{addr: 5'd8, data: 32'h0000_0088});
        @(negedge clk);
        checkOutput("b2b_release_stall", wb_stall, 0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b_pending", 32'(expQ.size()), 0);

        $display("[TB] Forwarding");
        fwd_raddr1 = 5'd9;
        fwd_raddr2 = 5'd10;
        doNonLoad(1'b1, 5'd9, 2'b00, 32'hCAFE_F00D, 32'h0, 32'h0, 32'hCAFE_F00D);
        checkOutput("fwd_hit1", fwd_hit1, 1);
        checkOutput("fwd_data1", fwd_data1, 32'hCAFE_F00D);
        checkOutput("fwd_hit2", fwd_hit2, 0);
        checkOutput("fwd_data2", fwd_data2, 0);
        @(posedge clk);
        #1;
        checkOutput("fwd_hit1_expired", fwd_hit1, 0);
        checkOutput("fwd_data1_expired", fwd_data1, 0);

        $display("[TB] Load timeout");
        applyStimulus(1'b1, 5'd12, 2'b01, 32'h0000_7000, 32'h0, 32'h0, 3'b010);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checkOutput("timeout_wait_stall", wb_stall, 1);
            checkOutput("timeout_wait_flag", load_timeout, 0);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("timeout_flag", load_timeout, 1);
        checkOutput("timeout_stall_drop", wb_stall, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1212_1212;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("timeout_sticky", load_timeout, 1);
        checkOutput("stray_rvalid_stall", wb_stall, 0);

        $display("[TB] Reset during LOAD_WAIT");
        applyStimulus(1'b1, 5'd13, 2'b01, 32'h0000_8000, 32'h0, 32'h0, 3'b010);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midload_reset_stall", wb_stall, 0);
        checkOutput("midload_reset_timeout", load_timeout, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1313_1313;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midload_no_stall", wb_stall, 0);
        checkOutput("final_pending", 32'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
